// File: rtl/float_pkg.sv
// Shared floating-point definitions.
//   float_width : width of one IEEE-754 single-precision word.
//   float_t     : one float word.
package float_pkg;

  localparam int float_width = 32;

  typedef logic [float_width-1:0] float_t;

endpackage

// File: rtl/float_mul_arbiter_if.sv
// Bus bundle between a float_mul_arbiter, its requesters and the shared
// multiplier.
//   Requester side : req (level), a/b (flattened operands), ack (one-hot
//                    pulse), out (result).
//   Multiplier side: mul_req (issue pulse), mul_a/mul_b (operands),
//                    mul_ack (done pulse), mul_out (result).
//   Status         : busy, err.
// slave  : the arbiter's view.
// master : the environment's view (requesters plus multiplier).
interface float_mul_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import float_pkg::*;

  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ*float_width-1:0] a;
  logic [NUM_REQ*float_width-1:0] b;
  logic [NUM_REQ-1:0]             ack;
  float_t                         out;
  logic                           busy;
  logic                           err;
  logic                           mul_req;
  float_t                         mul_a;
  float_t                         mul_b;
  logic                           mul_ack;
  float_t                         mul_out;

  modport slave (
    input  req, a, b, mul_ack, mul_out,
    output ack, out, busy, err, mul_req, mul_a, mul_b
  );

  modport master (
    output req, a, b, mul_ack, mul_out,
    input  ack, out, busy, err, mul_req, mul_a, mul_b
  );

endinterface

// File: rtl/float_mul_arbiter.sv
// Round-robin arbiter sharing one multi-cycle float multiplier between
// NUM_REQ requesters.
//   clk : rising-edge clock.
//   rst : synchronous, active-low reset.
//   bus : float_mul_arbiter_if.slave (requests, operands, acks, result,
//         multiplier handshake, busy and sticky watchdog err).
// Flow: IDLE picks a requester and pulses mul_req with its operands, WAIT
// holds until mul_ack (or the watchdog), RESP presents ack/out for one
// cycle and gives the requester a cycle to drop req. All outputs are
// registered.
module float_mul_arbiter
  import float_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 63
) (
  input logic                clk,
  input logic                rst,
  float_mul_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [WD_W-1:0]  wdog_t;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e             state_q, state_d;
  idx_t               grant_q, grant_d;
  idx_t               last_grant_q, last_grant_d;
  wdog_t              wdog_q, wdog_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  float_t             out_q, out_d;
  logic               mul_req_q, mul_req_d;
  float_t             mul_a_q, mul_a_d;
  float_t             mul_b_q, mul_b_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  float_t             a_arr [NUM_REQ];
  float_t             b_arr [NUM_REQ];
  logic               pick_valid;
  idx_t               pick_idx;
  logic               wdog_expire;

  // Unpack the flattened operand buses so the winner can be selected by index.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = bus.a[i*float_width +: float_width];
    assign b_arr[i] = bus.b[i*float_width +: float_width];
  end

  // Round-robin pick: first set req bit scanning upward from last_grant+1.
  always_comb begin
    idx_t cand;
    // NOTE: every variable written in a combinational block gets a default
    // first, otherwise paths that skip an assignment infer a latch.
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = idx_t'((int'(last_grant_q) + k) % NUM_REQ);
      if (!pick_valid && bus.req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // The counter value after this WAIT cycle would reach TIMEOUT.
  assign wdog_expire = (int'(wdog_q) + 1 >= TIMEOUT);

  // State register plus all registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; rst is only acted on at the clock edge.
    if (!rst) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= idx_t'(NUM_REQ - 1);
      wdog_q       <= '0;
      ack_q        <= '0;
      out_q        <= '0;
      mul_req_q    <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      wdog_q       <= wdog_d;
      ack_q        <= ack_d;
      out_q        <= out_d;
      mul_req_q    <= mul_req_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (pick_valid) state_d = S_WAIT;
      S_WAIT: if (bus.mul_ack || wdog_expire) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic. ack, out and mul_req default to 0 so they
  // are single-cycle pulses; operands, grant and err hold.
  always_comb begin
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    wdog_d       = wdog_q;
    ack_d        = '0;
    out_d        = '0;
    mul_req_d    = 1'b0;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    err_d        = err_q;
    busy_d       = (state_d != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          grant_d      = pick_idx;
          last_grant_d = pick_idx;
          mul_a_d      = a_arr[pick_idx];
          mul_b_d      = b_arr[pick_idx];
          mul_req_d    = 1'b1;
          wdog_d       = '0;
        end
      end
      S_WAIT: begin
        if (bus.mul_ack) begin
          out_d          = bus.mul_out;
          ack_d[grant_q] = 1'b1;
          wdog_d         = '0;
        end else if (wdog_expire) begin
          // Release the requester with a zero result and flag the fault.
          err_d          = 1'b1;
          ack_d[grant_q] = 1'b1;
          wdog_d         = '0;
        end else begin
          wdog_d = wdog_q + wdog_t'(1);
        end
      end
      default: ;
    endcase
  end

  assign bus.ack     = ack_q;
  assign bus.out     = out_q;
  assign bus.mul_req = mul_req_q;
  assign bus.mul_a   = mul_a_q;
  assign bus.mul_b   = mul_b_q;
  assign bus.busy    = busy_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_float_mul_arbiter.sv
// Scoreboard bench for float_mul_arbiter: a mock multiplier with
// programmable latency, a round-robin reference model that predicts each
// grant, and a monitor that checks issue operands, ack, result and latency.
module tb_float_mul_arbiter;
  import float_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  float_mul_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  float_mul_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int     idx;
    float_t a;
    float_t b;
    float_t prod;
    int     lat;
    bit     tmo;
  } exp_t;

  exp_t               sb[$];
  logic [NUM_REQ-1:0] grant_log[$];
  int                 checks = 0;
  int                 passes = 0;
  int                 cyc = 0;
  int                 ack_count = 0;
  int                 issue_cyc = 0;
  bit                 issued = 0;
  bit                 mock_dead = 0;
  int                 mock_lat = 1;
  int                 model_last = NUM_REQ - 1;
  float_t             op_a[NUM_REQ];
  float_t             op_b[NUM_REQ];
  float_t             op_p[NUM_REQ];
  int                 nrem[NUM_REQ];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic bit is_zero(float_t x);
    return x[30:23] == 8'd0;
  endfunction

  // Behaviour of the multiplier for the operand set used here: exact
  // products of short-mantissa normals, zero when either input is zero.
  function automatic float_t fmul(float_t x, float_t y);
    logic [47:0] ma, mb, p;
    logic [22:0] m;
    int          ex;
    if (is_zero(x) || is_zero(y)) return {x[31] ^ y[31], 31'b0};
    ma = {24'b0, 1'b1, x[22:0]};
    mb = {24'b0, 1'b1, y[22:0]};
    p  = ma * mb;
    ex = int'(x[30:23]) + int'(y[30:23]) - 127;
    if (p[47]) begin
      m = p[46:24];
      ex++;
    end else begin
      m = p[45:23];
    end
    return {x[31] ^ y[31], ex[7:0], m};
  endfunction

  function automatic float_t rand_float();
    logic [7:0] e;
    logic [7:0] mh;
    if ($urandom_range(0, 7) == 0) return 32'h0000_0000;
    e  = 8'($urandom_range(100, 154));
    mh = 8'($urandom_range(0, 255));
    return {1'($urandom_range(0, 1)), e, mh, 15'b0};
  endfunction

  function automatic int rr_pick(logic [NUM_REQ-1:0] r, int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int i;
      i = (last + k) % NUM_REQ;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic new_ops(int i);
    op_a[i] = rand_float();
    op_b[i] = rand_float();
    op_p[i] = fmul(op_a[i], op_b[i]);
  endtask

  task automatic drive_ops();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.a[i*float_width +: float_width] = op_a[i];
      bus.b[i*float_width +: float_width] = op_b[i];
    end
  endtask

  // Predict the next grant from the current request set and queue it.
  task automatic push_next(output int w);
    exp_t e;
    w = rr_pick(bus.req, model_last);
    if (w >= 0) begin
      model_last = w;
      e.idx  = w;
      e.a    = op_a[w];
      e.b    = op_b[w];
      e.tmo  = mock_dead;
      e.prod = mock_dead ? 32'h0 : op_p[w];
      if (mock_dead) e.lat = TIMEOUT;
      else e.lat = 1 + ((is_zero(op_a[w]) || is_zero(op_b[w])) ? 1 : mock_lat);
      sb.push_back(e);
    end
  endtask

  task automatic flush_model();
    sb.delete();
    issued     = 0;
    model_last = NUM_REQ - 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.req = '0;
    rst     = 1'b0;
    @(negedge clk);
    check("rst ack", bus.ack, 0);
    check("rst out", bus.out, 0);
    check("rst mul_req", bus.mul_req, 0);
    check("rst mul_a", bus.mul_a, 0);
    check("rst mul_b", bus.mul_b, 0);
    check("rst busy", bus.busy, 0);
    check("rst err", bus.err, 0);
    rst = 1'b1;
    flush_model();
  endtask

  // Serve the current request set until every requester has used up nrem.
  task automatic run_phase();
    int w;
    int budget;
    push_next(w);
    while (w >= 0) begin
      budget = 0;
      do begin
        @(negedge clk);
        budget++;
      end while (bus.ack == '0 && budget < 40);
      check("ack within budget", (bus.ack != '0), 1);
      if (bus.ack == '0) begin
        do_reset();
        return;
      end
      nrem[w]--;
      if (nrem[w] > 0) begin
        new_ops(w);
        drive_ops();
      end else begin
        bus.req[w] = 1'b0;
      end
      push_next(w);
    end
  endtask

  // Mock multiplier: acks mock_lat cycles after mul_req, 1 cycle for a zero
  // operand, never while mock_dead. Shares rst with the arbiter.
  initial begin
    int     cnt;
    float_t res;
    cnt = 0;
    res = '0;
    bus.mul_ack = 1'b0;
    bus.mul_out = '0;
    forever begin
      @(negedge clk);
      bus.mul_ack = 1'b0;
      bus.mul_out = '0;
      if (!rst) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            bus.mul_ack = 1'b1;
            bus.mul_out = res;
          end
        end
        if (bus.mul_req && !mock_dead) begin
          res = fmul(bus.mul_a, bus.mul_b);
          cnt = (is_zero(bus.mul_a) || is_zero(bus.mul_b)) ? 1 : mock_lat;
        end
      end
    end
  end

  // Monitor: checks issue and response against the scoreboard front.
  initial begin
    exp_t               e;
    logic [NUM_REQ-1:0] oh;
    forever begin
      @(negedge clk);
      if (rst && bus.mul_req) begin
        check("sb entry at mul_req", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
          check("mul_req single pulse", issued, 0);
          check("mul_a", bus.mul_a, sb[0].a);
          check("mul_b", bus.mul_b, sb[0].b);
          issued    = 1;
          issue_cyc = cyc;
        end
      end
      if (rst && bus.ack != '0) begin
        ack_count++;
        grant_log.push_back(bus.ack);
        check("sb entry at ack", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e  = sb.pop_front();
          oh = '0;
          oh[e.idx] = 1'b1;
          check("ack one-hot", bus.ack, oh);
          check("out", bus.out, e.prod);
          check("latency", cyc - issue_cyc, e.lat);
          if (e.tmo) check("err on timeout", bus.err, 1);
          issued = 0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int                 w;
    int                 budget;
    int                 saved;
    logic [NUM_REQ-1:0] fair_exp[6];

    bus.req = '0;
    bus.a   = '0;
    bus.b   = '0;
    for (int i = 0; i < NUM_REQ; i++) new_ops(i);
    drive_ops();
    do_reset();

    // Single request.
    op_a[0] = 32'h4000_0000; op_b[0] = 32'h4040_0000; op_p[0] = 32'h40C0_0000;
    drive_ops();
    mock_lat = 2;
    nrem[0]  = 1;
    bus.req  = 4'b0001;
    run_phase();

    // Two simultaneous requests: 1 then 2.
    op_a[1] = 32'h3FC0_0000; op_b[1] = 32'h3FC0_0000; op_p[1] = 32'h4010_0000;
    op_a[2] = 32'h4000_0000; op_b[2] = 32'h4080_0000; op_p[2] = 32'h4100_0000;
    drive_ops();
    grant_log.delete();
    nrem[1] = 1; nrem[2] = 1;
    bus.req = 4'b0110;
    run_phase();
    check("simul grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("simul first", grant_log[0], 4'b0010);
      check("simul second", grant_log[1], 4'b0100);
    end

    // Fairness from reset: all four held, order 0,1,2,3,0,1.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) new_ops(i);
    drive_ops();
    grant_log.delete();
    mock_lat = 1;
    nrem[0] = 2; nrem[1] = 2; nrem[2] = 1; nrem[3] = 1;
    bus.req = 4'b1111;
    run_phase();
    fair_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    check("fair grants", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      check($sformatf("fair grant %0d", i), grant_log[i], fair_exp[i]);

    // Zero-operand fast path.
    op_a[0] = 32'h0000_0000; op_b[0] = 32'h3F80_0000; op_p[0] = 32'h0000_0000;
    drive_ops();
    mock_lat = 3;
    nrem[0]  = 1;
    bus.req  = 4'b0001;
    run_phase();

    // Randomised request sets, repeat counts and latencies.
    for (int r = 0; r < 12; r++) begin
      logic [NUM_REQ-1:0] rq;
      rq = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      for (int i = 0; i < NUM_REQ; i++) begin
        new_ops(i);
        nrem[i] = $urandom_range(1, 3);
      end
      drive_ops();
      mock_lat = $urandom_range(1, 3);
      bus.req  = rq;
      run_phase();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Watchdog: multiplier never acks.
    mock_dead = 1;
    new_ops(0);
    drive_ops();
    nrem[0] = 1;
    bus.req = 4'b0001;
    run_phase();
    repeat (3) @(negedge clk);
    check("err sticky", bus.err, 1);
    check("idle after timeout", bus.busy, 0);

    // Reset in the middle of WAIT abandons the transaction.
    mock_dead = 0;
    mock_lat  = 3;
    new_ops(1);
    drive_ops();
    bus.req = 4'b0010;
    push_next(w);
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!bus.mul_req && budget < 10);
    check("issue before reset", bus.mul_req, 1);
    @(negedge clk);
    check("busy mid-wait", bus.busy, 1);
    saved = ack_count;
    bus.req = '0;
    rst     = 1'b0;
    @(negedge clk);
    check("midrst ack", bus.ack, 0);
    check("midrst out", bus.out, 0);
    check("midrst mul_req", bus.mul_req, 0);
    check("midrst mul_a", bus.mul_a, 0);
    check("midrst mul_b", bus.mul_b, 0);
    check("midrst busy", bus.busy, 0);
    check("midrst err cleared", bus.err, 0);
    rst = 1'b1;
    flush_model();
    repeat (10) @(negedge clk);
    check("no ack after abandon", ack_count, saved);

    // Priority restarts at requester 0 after reset.
    grant_log.delete();
    for (int i = 0; i < NUM_REQ; i++) new_ops(i);
    drive_ops();
    mock_lat = 2;
    nrem[1] = 1; nrem[3] = 1;
    bus.req = 4'b1010;
    run_phase();
    check("post-reset grants", grant_log.size(), 2);
    if (grant_log.size() == 2) check("post-reset first", grant_log[0], 4'b0010);

    repeat (3) @(negedge clk);
    check("scoreboard drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/float_mul_arbiter.md
Name: float_mul_arbiter

Overview:
- Shares one multi-cycle float multiplier (req/ack handshake, a/b operands, out result) between NUM_REQ requesters, for example per-lane FPU issue slots.
- Arbitration is round-robin. Operands are latched and issued as a one-cycle req pulse, and the arbiter waits for the multiplier's one-cycle ack.
- The result is returned to the granted requester with a one-cycle ack.
- A watchdog flags a multiplier that never acknowledges.

Parameters:
- NUM_REQ, 4, number of requesters (at least 2).
- TIMEOUT, 63, maximum cycles in WAIT before the watchdog fires.
- float_width, 32, taken from the shared float package, not overridable.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- req  in  NUM_REQ  per-requester level request; held high until the matching ack is seen.
- a  in  NUM_REQ*float_width  flattened operands; requester i uses bits [i*float_width +: float_width]. Stable while req[i] is high.
- b  in  NUM_REQ*float_width  flattened operands, same layout as a.
- ack  out  NUM_REQ  one-hot, one-cycle result-valid pulse.
- out  out  float_width  result; valid only while ack is nonzero.
- busy  out  1  high in every state other than IDLE.
- err  out  1  sticky watchdog flag.
- mul_req  out  1  one-cycle issue pulse to the multiplier.
- mul_a  out  float_width  operand to the multiplier.
- mul_b  out  float_width  operand to the multiplier.
- mul_ack  in  1  multiplier done pulse.
- mul_out  in  float_width  multiplier result.

Behaviour:
- Reset (rst low at a rising edge):
  - state is IDLE; ack, out, mul_req, mul_a, mul_b, busy and err are all 0.
  - grant is 0; last_grant is NUM_REQ-1, so requester 0 has first priority.
  - wdog is 0.
  - Reset mid-operation abandons the transaction with no ack. The multiplier shares rst and is reset in the same cycle.
- All outputs are registered.
- IDLE:
  - If req is nonzero, pick the first set bit scanning upward from (last_grant+1) mod NUM_REQ, wrapping around.
  - Latch that index into grant and last_grant. Load mul_a and mul_b from that requester's slices and set mul_req=1 for one cycle.
  - Next state is WAIT. With req=0, remain in IDLE.
- WAIT:
  - mul_req=0, and mul_a/mul_b hold their values.
  - wdog increments each cycle in WAIT.
  - If mul_ack=1: out<=mul_out, ack[grant]<=1, wdog<=0, next state RESP.
  - mul_ack can arrive on the first WAIT cycle (zero-operand fast path, one cycle after mul_req) and must be handled there.
  - Else if wdog reaches TIMEOUT: err<=1, ack[grant]<=1, out<=0, next state RESP.
- RESP:
  - ack and out are high/valid for exactly this cycle. No arbitration happens here, which gives the requester one cycle to drop req.
  - Next state is IDLE, with ack<=0 and out<=0.
- mul_ack outside WAIT is ignored.
- err stays set until reset.
- Latency from req rising, seen in IDLE at edge k:
  - mul_req high after edge k.
  - ack high after edge k+1+L, where L is the multiplier latency in cycles from mul_req to mul_ack (L=1 on the fast path).
  - Minimum request-to-request spacing is 3+L cycles.
- Fairness: a requester holding req is served within NUM_REQ grants.

Test Plan:
- Single request: req=0001, a0=0x40000000, b0=0x40400000 -> mul_req pulses once with mul_a=0x40000000, mul_b=0x40400000. Then ack=0001 for one cycle with out=0x40C00000.
- Simultaneous requests: req=0110, a1=b1=0x3FC00000, a2=0x40000000, b2=0x40800000. Required: grant 1 first with out=0x40100000, then grant 2 with out=0x41000000.
- Fairness: all four requesters held high and re-asserted after each ack -> grant order 0,1,2,3,0,1 across 6 grants, and exactly one ack bit per transaction.
- Fast path: a0=0x00000000, b0=0x3F800000 -> mul_ack arrives on the first WAIT cycle, and ack=0001 appears one cycle later with out=0x00000000.
- Watchdog and reset:
  - mul_ack tied to 0 with TIMEOUT=5 -> after 5 WAIT cycles, err=1 and ack pulses with out=0.
  - Then drop rst for one cycle mid-WAIT on a new request -> all outputs are 0, state returns to IDLE, no ack is issued, and err is cleared.
